// File: rtl/mem_reinit_pkg.sv
// Shared types and CRC-32 helpers for the RAM reinit / readback blocks.
package mem_reinit_pkg;

  typedef enum logic [1:0] {IDLE, FILL, SEND, DONE} rb_state_t;

  localparam logic [31:0] CRC32_POLY   = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;
  localparam int          CRC_MAX_W    = 256;

  // Reflected CRC-32, data consumed LSB first; only the low nbits of data are used.
  function automatic logic [31:0] crc32_update(input logic [31:0]          crc,
                                               input logic [CRC_MAX_W-1:0] data,
                                               input int                   nbits);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < CRC_MAX_W; i++) begin
      if (i < nbits) begin
        if (c[0] ^ data[i]) c = (c >> 1) ^ CRC32_POLY;
        else                c = c >> 1;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_accum.sv
// Running CRC-32 register: one DATA_W-bit word folded in per enabled cycle.
module crc32_accum
  import mem_reinit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_enable,
  input  logic [DATA_W-1:0] i_data,
  output logic [31:0]       o_crc
);

  logic [31:0] r_crc;

  if (DATA_W > CRC_MAX_W) begin : g_bad_width
    $error("crc32_accum: DATA_W exceeds CRC_MAX_W");
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_crc <= CRC32_INIT;
    end else if (i_clear) begin
      r_crc <= CRC32_INIT;
    end else if (i_enable) begin
      r_crc <= crc32_update(r_crc, CRC_MAX_W'(i_data), DATA_W);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/mem_readback_streamer.sv
// Sweeps a 1-cycle-latency RAM, packs elements into beats and streams them out
// with a running CRC-32 of every accepted beat.
//   state | meaning
//   IDLE  | waiting for start after reset
//   FILL  | issuing reads / capturing elements for the current beat
//   SEND  | beat presented on m_data, waiting for m_ready
//   DONE  | sweep complete, crc valid, waiting for a new start
module mem_readback_streamer
  import mem_reinit_pkg::*;
#(
  parameter int WID_MEM   = 1,
  parameter int DEPTH_MEM = 131072,
  parameter int PACK_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [31:0]        mem_raddr,
  input  logic [WID_MEM-1:0] mem_dout,
  output logic [PACK_W-1:0]  m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last,
  output logic               busy,
  output logic               done,
  output logic [31:0]        crc
);

  localparam int ELEMS = PACK_W / WID_MEM;
  localparam int AW    = $clog2(DEPTH_MEM + 1);
  localparam int SW    = $clog2(ELEMS + 1);
  localparam logic [AW-1:0] DEPTH_L   = AW'(DEPTH_MEM);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH_MEM - 1);
  localparam logic [SW-1:0] ELEMS_L   = SW'(ELEMS);

  if (PACK_W % WID_MEM != 0) begin : g_bad_pack
    $error("mem_readback_streamer: PACK_W must be a multiple of WID_MEM");
  end

  rb_state_t         r_state;
  logic [AW-1:0]     r_addr;
  logic [AW-1:0]     r_raddr;
  logic [SW-1:0]     r_issued;
  logic [SW-1:0]     r_captured;
  logic [SW-1:0]     r_rd_slot;
  logic              r_rd_pend;
  logic              r_rd_last;
  logic [PACK_W-1:0] r_pack;
  logic [PACK_W-1:0] r_m_data;
  logic              r_m_valid;
  logic              r_m_last;
  logic              r_busy;
  logic              r_done;

  logic              w_start_ok;
  logic              w_accept;
  logic              w_issue;
  logic              w_beat_full;
  logic [PACK_W-1:0] w_pack_next;
  logic [31:0]       w_crc;

  assign w_start_ok  = start && (r_state == IDLE || r_state == DONE);
  assign w_accept    = (r_state == SEND) && r_m_valid && m_ready;
  assign w_issue     = (r_state == FILL) && (r_issued < ELEMS_L) && (r_addr < DEPTH_L);
  // The read returning this cycle either fills the last slot or carries the final address.
  assign w_beat_full = r_rd_pend && ((r_captured == ELEMS_L - 1'b1) || r_rd_last);

  always_comb begin
    w_pack_next = r_pack;
    if (r_rd_pend) w_pack_next[int'(r_rd_slot)*WID_MEM +: WID_MEM] = mem_dout;
  end

  crc32_accum #(.DATA_W(PACK_W)) u_crc (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_start_ok),
    .i_enable (w_accept),
    .i_data   (r_m_data),
    .o_crc    (w_crc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_raddr    <= '0;
      r_issued   <= '0;
      r_captured <= '0;
      r_rd_slot  <= '0;
      r_rd_pend  <= 1'b0;
      r_rd_last  <= 1'b0;
      r_pack     <= '0;
      r_m_data   <= '0;
      r_m_valid  <= 1'b0;
      r_m_last   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_start_ok) begin
            r_state    <= FILL;
            r_addr     <= '0;
            r_raddr    <= '0;
            r_issued   <= '0;
            r_captured <= '0;
            r_rd_pend  <= 1'b0;
            r_rd_last  <= 1'b0;
            r_pack     <= '0;
            r_m_last   <= 1'b0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
          end
        end
        FILL: begin
          r_rd_pend <= w_issue;
          if (w_issue) begin
            r_addr    <= r_addr + 1'b1;
            r_issued  <= r_issued + 1'b1;
            r_rd_slot <= r_issued;
            r_rd_last <= (r_addr == LAST_ADDR);
            // mem_raddr parks on the final address once the sweep has issued it.
            if (r_addr != LAST_ADDR) r_raddr <= r_addr + 1'b1;
          end
          if (r_rd_pend) begin
            r_pack     <= w_pack_next;
            r_captured <= r_captured + 1'b1;
          end
          if (w_beat_full) begin
            r_state   <= SEND;
            r_m_data  <= w_pack_next;
            r_m_valid <= 1'b1;
            r_m_last  <= r_rd_last;
          end
        end
        SEND: begin
          if (w_accept) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            if (r_m_last) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state    <= FILL;
              r_issued   <= '0;
              r_captured <= '0;
              r_pack     <= '0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_raddr = 32'(r_raddr);
  assign m_data    = r_m_data;
  assign m_valid   = r_m_valid;
  assign m_last    = r_m_last;
  assign busy      = r_busy;
  assign done      = r_done;
  assign crc       = (r_state == DONE) ? (w_crc ^ CRC32_XOROUT) : 32'h0;

endmodule

// File: tb/tb_mem_readback_streamer.sv
// Directed + randomized bench: three streamer instances each paired with a
// registered-read RAM model, checked against a beat/CRC reference model.
module tb_mem_readback_streamer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   sel;
  logic start_v, ready_v;

  // instance A: WID 1, DEPTH 8, PACK 4
  logic [31:0] raddr_a;  logic dout_a;  logic [3:0] data_a;
  logic valid_a, last_a, busy_a, done_a;  logic [31:0] crc_a;
  logic mem_a [8];
  // instance B: WID 1, DEPTH 6, PACK 4
  logic [31:0] raddr_b;  logic dout_b;  logic [3:0] data_b;
  logic valid_b, last_b, busy_b, done_b;  logic [31:0] crc_b;
  logic mem_b [8];
  // instance C: WID 8, DEPTH 4, PACK 32
  logic [31:0] raddr_c;  logic [7:0] dout_c;  logic [31:0] data_c;
  logic valid_c, last_c, busy_c, done_c;  logic [31:0] crc_c;
  logic [7:0] mem_c [4];

  mem_readback_streamer #(.WID_MEM(1), .DEPTH_MEM(8), .PACK_W(4)) u_a (
    .clk(clk), .reset(reset), .start(start_v && sel == 0), .mem_raddr(raddr_a),
    .mem_dout(dout_a), .m_data(data_a), .m_valid(valid_a), .m_ready(ready_v && sel == 0),
    .m_last(last_a), .busy(busy_a), .done(done_a), .crc(crc_a));

  mem_readback_streamer #(.WID_MEM(1), .DEPTH_MEM(6), .PACK_W(4)) u_b (
    .clk(clk), .reset(reset), .start(start_v && sel == 1), .mem_raddr(raddr_b),
    .mem_dout(dout_b), .m_data(data_b), .m_valid(valid_b), .m_ready(ready_v && sel == 1),
    .m_last(last_b), .busy(busy_b), .done(done_b), .crc(crc_b));

  mem_readback_streamer #(.WID_MEM(8), .DEPTH_MEM(4), .PACK_W(32)) u_c (
    .clk(clk), .reset(reset), .start(start_v && sel == 2), .mem_raddr(raddr_c),
    .mem_dout(dout_c), .m_data(data_c), .m_valid(valid_c), .m_ready(ready_v && sel == 2),
    .m_last(last_c), .busy(busy_c), .done(done_c), .crc(crc_c));

  always @(posedge clk) begin
    dout_a <= mem_a[raddr_a[2:0]];
    dout_b <= (raddr_b < 32'd6) ? mem_b[raddr_b[2:0]] : 1'b0;
    dout_c <= mem_c[raddr_c[1:0]];
  end

  logic [31:0] s_raddr, s_data, s_crc;
  logic        s_valid, s_last, s_busy, s_done;
  always_comb begin
    case (sel)
      0: begin s_raddr = raddr_a; s_data = {28'b0, data_a}; s_crc = crc_a;
               s_valid = valid_a; s_last = last_a; s_busy = busy_a; s_done = done_a; end
      1: begin s_raddr = raddr_b; s_data = {28'b0, data_b}; s_crc = crc_b;
               s_valid = valid_b; s_last = last_b; s_busy = busy_b; s_done = done_b; end
      default: begin s_raddr = raddr_c; s_data = data_c; s_crc = crc_c;
               s_valid = valid_c; s_last = last_c; s_busy = busy_c; s_done = done_c; end
    endcase
  end

  logic [31:0] exp_d[$];
  logic        exp_l[$];
  logic [31:0] exp_crc;
  int          exp_depth, exp_elems;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: slice the selected RAM image into beats, then CRC the beat stream.
  task automatic build_model(input int id);
    int w, nb, idx, elem;
    logic [31:0] beat, c;
    case (id)
      0: begin exp_depth = 8; w = 1; exp_elems = 4; end
      1: begin exp_depth = 6; w = 1; exp_elems = 4; end
      default: begin exp_depth = 4; w = 8; exp_elems = 4; end
    endcase
    exp_d.delete(); exp_l.delete();
    nb = (exp_depth + exp_elems - 1) / exp_elems;
    c = 32'hFFFFFFFF;
    for (int b = 0; b < nb; b++) begin
      beat = 0;
      for (int k = 0; k < exp_elems; k++) begin
        idx = b * exp_elems + k;
        if (idx < exp_depth) begin
          elem = (id == 0) ? int'(mem_a[idx]) : (id == 1) ? int'(mem_b[idx]) : int'(mem_c[idx]);
          beat = beat | (32'(elem) << (k * w));
        end
      end
      exp_d.push_back(beat);
      exp_l.push_back(b == nb - 1);
      for (int i = 0; i < exp_elems * w; i++) begin
        if (c[0] ^ beat[i]) c = (c >> 1) ^ 32'hEDB88320;
        else                c = c >> 1;
      end
    end
    exp_crc = c ^ 32'hFFFFFFFF;
  endtask

  task automatic sweep(input bit rand_ready, input int stall, input bit poke, output logic [31:0] crc_out);
    logic [31:0] got_d[$];
    logic        got_l[$];
    int lat, stall_left, max_ra;
    bit prev_v, prev_acc, poked_send;
    logic [31:0] hold_d, hold_ra;
    logic        hold_l;
    lat = -1; stall_left = stall; max_ra = 0;
    prev_v = 0; prev_acc = 0; poked_send = 0;
    hold_d = 0; hold_ra = 0; hold_l = 0;
    @(negedge clk); start_v = 1'b1; ready_v = 1'b0;
    @(negedge clk); start_v = 1'b0;
    check("start_done_clr", {31'b0, s_done}, 32'd0);
    check("start_busy", {31'b0, s_busy}, 32'd1);
    check("start_raddr", s_raddr, 32'd0);
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (cyc > 0) @(negedge clk);
      start_v = 1'b0;
      if (s_done) break;
      if (poke && cyc == 2) start_v = 1'b1;
      if (poke && s_valid && !poked_send) begin start_v = 1'b1; poked_send = 1; end
      if (s_raddr > 32'(max_ra)) max_ra = int'(s_raddr);
      if (prev_v && !prev_acc) begin
        check("valid_held", {31'b0, s_valid}, 32'd1);
        check("data_held", s_data, hold_d);
        check("last_held", {31'b0, s_last}, {31'b0, hold_l});
        check("raddr_frozen", s_raddr, hold_ra);
      end
      if (s_valid && lat < 0) lat = cyc;
      if (s_valid && stall_left > 0) begin
        ready_v = 1'b0;
        stall_left--;
      end else begin
        ready_v = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      prev_v = s_valid; prev_acc = s_valid && ready_v;
      hold_d = s_data; hold_l = s_last; hold_ra = s_raddr;
      if (prev_acc) begin got_d.push_back(s_data); got_l.push_back(s_last); end
    end
    ready_v = 1'b0;
    check("done_reached", {31'b0, s_done}, 32'd1);
    check("busy_after_done", {31'b0, s_busy}, 32'd0);
    check("latency", 32'(lat), 32'(exp_elems + 1));
    check("raddr_max", 32'(max_ra), 32'(exp_depth - 1));
    check("raddr_final", s_raddr, 32'(exp_depth - 1));
    check("n_beats", 32'(got_d.size()), 32'(exp_d.size()));
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      check("beat_data", got_d[i], exp_d[i]);
      check("beat_last", {31'b0, got_l[i]}, {31'b0, exp_l[i]});
    end
    check("crc", s_crc, exp_crc);
    crc_out = s_crc;
  endtask

  initial begin : main
    logic [31:0] crc1, crc_x;
    logic init_bits [8];
    init_bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin mem_a[i] = init_bits[i]; mem_b[i] = init_bits[i]; end
    mem_c = '{8'h11, 8'h22, 8'h33, 8'h44};
    sel = 0; start_v = 0; ready_v = 0; reset = 1'b0;
    #1;
    check("rst_valid", {31'b0, valid_a}, 32'd0);
    check("rst_data", {28'b0, data_a}, 32'd0);
    check("rst_busy_done", {30'b0, busy_a, done_a}, 32'd0);
    check("rst_crc", crc_a, 32'd0);
    check("rst_raddr", raddr_a, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    build_model(0); sweep(0, 0, 0, crc1);          // basic sweep
    sel = 1; build_model(1); sweep(0, 0, 0, crc_x); // partial last beat
    sel = 0; build_model(0); sweep(0, 10, 0, crc_x); // backpressure on first beat
    check("crc_stall_eq", crc_x, crc1);

    // abort mid-sweep, one cycle after the second beat's first read
    ready_v = 1'b1;
    @(negedge clk); start_v = 1'b1;
    @(negedge clk); start_v = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_abort_raddr", raddr_a, 32'd5);
    reset = 1'b0;
    #1;
    check("abort_valid", {31'b0, valid_a}, 32'd0);
    check("abort_data", {28'b0, data_a}, 32'd0);
    check("abort_busy_last", {30'b0, busy_a, last_a}, 32'd0);
    check("abort_raddr", raddr_a, 32'd0);
    @(negedge clk); reset = 1'b1;
    repeat (10) @(negedge clk);
    check("post_abort_idle", {29'b0, valid_a, done_a, busy_a}, 32'd0);
    ready_v = 1'b0;
    sweep(0, 0, 0, crc_x);
    check("crc_after_abort", crc_x, crc1);

    sweep(0, 0, 1, crc_x);                          // start pokes in FILL and SEND
    check("crc_poke", crc_x, crc1);
    sweep(0, 0, 0, crc_x);                          // restart from DONE
    check("crc_restart", crc_x, crc1);

    sel = 2; build_model(2); sweep(0, 0, 0, crc_x); // wide elements, single beat

    for (int r = 0; r < 4; r++) begin
      sel = 0;
      for (int i = 0; i < 8; i++) mem_a[i] = 1'($urandom_range(0, 1));
      build_model(0); sweep(1, int'($urandom_range(0, 5)), 0, crc_x);
      sel = 2;
      for (int i = 0; i < 4; i++) mem_c[i] = 8'($urandom_range(0, 255));
      build_model(2); sweep(1, int'($urandom_range(0, 5)), 0, crc_x);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
